// File: rtl/desc_sequencer.sv
// ============================================================================
// desc_sequencer : per-core descriptor table driving staged memory bursts
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module desc_sequencer #(
  parameter int MAIN_MEM_ADDR_WIDTH = 32,
  parameter int NUM_CORES           = 4,
  parameter int BURST_WIDTH         = 6,
  localparam int CORE_W             = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           w_clock,
  input  logic                           w_reset_n,
  input  logic                           w_cfg_we,
  input  logic [CORE_W-1:0]              w_cfg_core,
  input  logic [1:0]                     w_cfg_stage,
  input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_cfg_addr,
  input  logic [BURST_WIDTH-1:0]         w_cfg_burst,
  input  logic                           w_job_valid,
  input  logic [CORE_W-1:0]              w_job_core,
  input  logic                           w_job_rw,
  output logic                           w_job_ready,
  output logic                           w_mem_valid,
  input  logic                           w_mem_ready,
  output logic [MAIN_MEM_ADDR_WIDTH-1:0] w_mem_addr,
  output logic                           w_mem_rw,
  output logic [BURST_WIDTH-1:0]         w_mem_burst,
  output logic                           w_done,
  output logic [CORE_W-1:0]              w_done_core
);

  localparam int N_ENT = NUM_CORES * 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_XFER = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  logic [MAIN_MEM_ADDR_WIDTH-1:0] tbl_addr_q  [N_ENT];
  logic [MAIN_MEM_ADDR_WIDTH-1:0] tbl_addr_d  [N_ENT];
  logic [BURST_WIDTH-1:0]         tbl_burst_q [N_ENT];
  logic [BURST_WIDTH-1:0]         tbl_burst_d [N_ENT];

  state_t                         state_q, state_d;
  logic [CORE_W-1:0]              core_q, core_d;
  logic                           rw_q, rw_d;
  logic [1:0]                     stage_q, stage_d;
  logic [MAIN_MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BURST_WIDTH-1:0]         left_q, left_d;
  logic [BURST_WIDTH-1:0]         mem_burst_q, mem_burst_d;
  logic                           job_ready_q, job_ready_d;
  logic                           mem_valid_q, mem_valid_d;
  logic                           done_q, done_d;

  logic [MAIN_MEM_ADDR_WIDTH-1:0] rd_addr;
  logic [BURST_WIDTH-1:0]         rd_burst;

  // Entry index is core*4 + stage; cores beyond NUM_CORES never match an entry.
  always_comb begin
    for (int e = 0; e < N_ENT; e++) begin
      tbl_addr_d[e]  = tbl_addr_q[e];
      tbl_burst_d[e] = tbl_burst_q[e];
      if (w_cfg_we && (int'(w_cfg_core) == e / 4) && (int'(w_cfg_stage) == e % 4)) begin
        tbl_addr_d[e]  = w_cfg_addr;
        tbl_burst_d[e] = w_cfg_burst;
      end
    end
  end

  always_comb begin
    rd_addr  = '0;
    rd_burst = '0;
    for (int e = 0; e < N_ENT; e++) begin
      if ((int'(core_q) == e / 4) && (int'(stage_q) == e % 4)) begin
        rd_addr  = tbl_addr_q[e];
        rd_burst = tbl_burst_q[e];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    core_d      = core_q;
    rw_d        = rw_q;
    stage_d     = stage_q;
    addr_d      = addr_q;
    left_d      = left_q;
    mem_burst_d = mem_burst_q;
    case (state_q)
      ST_IDLE: begin
        if (w_job_valid && job_ready_q) begin
          core_d  = w_job_core;
          rw_d    = w_job_rw;
          stage_d = w_job_rw ? 2'd0 : 2'd3;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        addr_d      = rd_addr;
        left_d      = rd_burst;
        mem_burst_d = rd_burst;
        state_d     = (rd_burst != '0) ? ST_XFER : ST_NEXT;
      end
      ST_XFER: begin
        if (w_mem_ready) begin
          addr_d      = addr_q + MAIN_MEM_ADDR_WIDTH'(1);
          left_d      = left_q - BURST_WIDTH'(1);
          mem_burst_d = '0;
          if (left_q == BURST_WIDTH'(1)) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // Reads finish after acts (stage 2); writes have only the psum stage.
        if ((stage_q == 2'd2) || (stage_q == 2'd3)) begin
          state_d = ST_DONE;
        end else begin
          stage_d = stage_q + 2'd1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    job_ready_d = (state_d == ST_IDLE);
    mem_valid_d = (state_d == ST_XFER);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      for (int e = 0; e < N_ENT; e++) begin
        tbl_addr_q[e]  <= '0;
        tbl_burst_q[e] <= '0;
      end
      state_q     <= ST_IDLE;
      core_q      <= '0;
      rw_q        <= 1'b0;
      stage_q     <= 2'd0;
      addr_q      <= '0;
      left_q      <= '0;
      mem_burst_q <= '0;
      job_ready_q <= 1'b0;
      mem_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      tbl_addr_q  <= tbl_addr_d;
      tbl_burst_q <= tbl_burst_d;
      state_q     <= state_d;
      core_q      <= core_d;
      rw_q        <= rw_d;
      stage_q     <= stage_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      mem_burst_q <= mem_burst_d;
      job_ready_q <= job_ready_d;
      mem_valid_q <= mem_valid_d;
      done_q      <= done_d;
    end
  end

  assign w_job_ready = job_ready_q;
  assign w_mem_valid = mem_valid_q;
  assign w_mem_addr  = addr_q;
  assign w_mem_rw    = rw_q;
  assign w_mem_burst = mem_burst_q;
  assign w_done      = done_q;
  assign w_done_core = core_q;

endmodule

`default_nettype wire

// File: tb/tb_desc_sequencer.sv
// ============================================================================
// tb_desc_sequencer : scoreboard bench for desc_sequencer
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_desc_sequencer;
  localparam int AW = 32;
  localparam int NC = 4;
  localparam int BW = 6;
  localparam int CW = 2;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cfg_we    = 1'b0;
  logic [CW-1:0] cfg_core  = '0;
  logic [1:0]    cfg_stage = '0;
  logic [AW-1:0] cfg_addr  = '0;
  logic [BW-1:0] cfg_burst = '0;
  logic          job_valid = 1'b0;
  logic [CW-1:0] job_core  = '0;
  logic          job_rw    = 1'b0;
  logic          mem_ready = 1'b1;
  logic          job_ready, mem_valid, mem_rw, done;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_burst;
  logic [CW-1:0] done_core;

  always #5 clk = ~clk;

  desc_sequencer #(
    .MAIN_MEM_ADDR_WIDTH(AW),
    .NUM_CORES(NC),
    .BURST_WIDTH(BW)
  ) dut (
    .w_clock(clk),          .w_reset_n(rst_n),
    .w_cfg_we(cfg_we),      .w_cfg_core(cfg_core),   .w_cfg_stage(cfg_stage),
    .w_cfg_addr(cfg_addr),  .w_cfg_burst(cfg_burst),
    .w_job_valid(job_valid), .w_job_core(job_core),  .w_job_rw(job_rw),
    .w_job_ready(job_ready), .w_mem_valid(mem_valid), .w_mem_ready(mem_ready),
    .w_mem_addr(mem_addr),  .w_mem_rw(mem_rw),       .w_mem_burst(mem_burst),
    .w_done(done),          .w_done_core(done_core)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          rw;
    logic [BW-1:0] burst;
  } beat_t;

  typedef struct {
    int core;
    int cyc;
  } done_t;

  beat_t exp_beats[$];
  done_t exp_done[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    first_cyc   = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: compare every presented beat and done pulse against the scoreboard.
  initial begin
    beat_t got_b;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst_n && mem_valid) begin
        got_b = {mem_addr, mem_rw, mem_burst};
        if (exp_beats.size() == 0) begin
          fail_now("unexpected_beat", 64'(got_b), 64'h0);
        end else begin
          check(mem_ready ? "beat" : "stall_hold", 64'(got_b), 64'(exp_beats[0]));
          if (first_cyc >= 0) begin
            check("first_beat_cycle", 64'(cyc), 64'(first_cyc));
            first_cyc = -1;
          end
          if (mem_ready) void'(exp_beats.pop_front());
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          fail_now("unexpected_done", 64'(done_core), 64'h0);
        end else begin
          d = exp_done.pop_front();
          check("done_core", 64'(done_core), 64'(d.core));
          if (d.cyc >= 0) check("done_cycle", 64'(cyc), 64'(d.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_desc(input int core, input int stage, input logic [AW-1:0] a, input int b);
    cfg_we    = 1'b1;
    cfg_core  = CW'(core);
    cfg_stage = 2'(stage);
    cfg_addr  = a;
    cfg_burst = BW'(b);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic exp_beat(input logic [AW-1:0] a, input logic rw, input int b);
    exp_beats.push_back(beat_t'({a, rw, BW'(b)}));
  endtask

  task automatic exp_fin(input int core, input int c);
    done_t d;
    d.core = core;
    d.cyc  = c;
    exp_done.push_back(d);
  endtask

  // Returns the cycle number of the accepting edge.
  task automatic start_job(input int core, input logic rw, output int acc);
    int n = 0;
    while (!job_ready && n < 50) begin
      tick();
      n++;
    end
    if (!job_ready) fail_now("job_ready_timeout", 64'(job_ready), 64'h1);
    job_valid = 1'b1;
    job_core  = CW'(core);
    job_rw    = rw;
    tick();
    job_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_beats.size() != 0 || exp_done.size() != 0 || !job_ready) && n < 300) begin
      tick();
      n++;
    end
    if (exp_beats.size() != 0 || exp_done.size() != 0 || !job_ready) begin
      fail_now("drain_timeout", 64'(exp_beats.size() + exp_done.size()), 64'h0);
      exp_beats.delete();
      exp_done.delete();
    end
  endtask

  initial begin
    int acc;

    // Reset state
    tick();
    tick();
    check("rst_mem_valid", 64'(mem_valid), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_rw", 64'(mem_rw), 64'h0);
    check("rst_mem_burst", 64'(mem_burst), 64'h0);
    check("rst_done_core", 64'(done_core), 64'h0);
    check("rst_job_ready", 64'(job_ready), 64'h0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", 64'(job_ready), 64'h1);

    // Core 1 read, three stages, continuous ready, exact timing
    wr_desc(1, 0, 32'h100, 2);
    wr_desc(1, 1, 32'h200, 1);
    wr_desc(1, 2, 32'h300, 3);
    exp_beat(32'h100, 1'b1, 2);
    exp_beat(32'h101, 1'b1, 0);
    exp_beat(32'h200, 1'b1, 1);
    exp_beat(32'h300, 1'b1, 3);
    exp_beat(32'h301, 1'b1, 0);
    exp_beat(32'h302, 1'b1, 0);
    start_job(1, 1'b1, acc);
    first_cyc = acc + 1;
    exp_fin(1, acc + 12);
    wait_idle();

    // Core 2 write with address wrap
    wr_desc(2, 3, 32'hFFFF_FFFE, 3);
    exp_beat(32'hFFFF_FFFE, 1'b0, 3);
    exp_beat(32'hFFFF_FFFF, 1'b0, 0);
    exp_beat(32'h0000_0000, 1'b0, 0);
    start_job(2, 1'b0, acc);
    exp_fin(2, -1);
    wait_idle();

    // Core 0 read with a skipped weights stage
    wr_desc(0, 0, 32'h40, 1);
    wr_desc(0, 1, 32'h500, 0);
    wr_desc(0, 2, 32'h60, 2);
    exp_beat(32'h40, 1'b1, 1);
    exp_beat(32'h60, 1'b1, 2);
    exp_beat(32'h61, 1'b1, 0);
    start_job(0, 1'b1, acc);
    exp_fin(0, acc + 9);
    wait_idle();

    // Back-pressure for 5 cycles on the second beat
    wr_desc(3, 0, 32'h700, 3);
    exp_beat(32'h700, 1'b1, 3);
    exp_beat(32'h701, 1'b1, 0);
    exp_beat(32'h702, 1'b1, 0);
    start_job(3, 1'b1, acc);
    exp_fin(3, acc + 14);
    tick();
    tick();
    mem_ready = 1'b0;
    repeat (5) tick();
    mem_ready = 1'b1;
    wait_idle();

    // Rewrite of the active entry during XFER takes effect on the next job only
    exp_beat(32'hFFFF_FFFE, 1'b0, 3);
    exp_beat(32'hFFFF_FFFF, 1'b0, 0);
    exp_beat(32'h0000_0000, 1'b0, 0);
    start_job(2, 1'b0, acc);
    exp_fin(2, -1);
    tick();
    wr_desc(2, 3, 32'h800, 1);
    wait_idle();
    exp_beat(32'h800, 1'b0, 1);
    start_job(2, 1'b0, acc);
    exp_fin(2, acc + 3);
    wait_idle();

    // Reset during the third beat aborts the job and clears the table
    exp_beat(32'h100, 1'b1, 2);
    exp_beat(32'h101, 1'b1, 0);
    start_job(1, 1'b1, acc);
    repeat (5) tick();
    check("pre_reset_valid", 64'(mem_valid), 64'h1);
    check("pre_reset_addr", 64'(mem_addr), 64'h200);
    rst_n = 1'b0;
    #1;
    check("abort_mem_valid", 64'(mem_valid), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    check("abort_job_ready", 64'(job_ready), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_beats_left", 64'(exp_beats.size()), 64'h0);
    check("ready_after_abort", 64'(job_ready), 64'h1);
    start_job(1, 1'b1, acc);
    exp_fin(1, acc + 6);
    wait_idle();
    start_job(2, 1'b0, acc);
    exp_fin(2, acc + 2);
    wait_idle();
    start_job(3, 1'b1, acc);
    exp_fin(3, acc + 6);
    wait_idle();

    repeat (5) tick();
    check("end_beats_pending", 64'(exp_beats.size()), 64'h0);
    check("end_done_pending", 64'(exp_done.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/desc_sequencer.md
DESC_SEQUENCER -- requirements
Module: desc_sequencer

Interface
REQ-001 SHALL have parameter MAIN_MEM_ADDR_WIDTH, default 32, main memory address width.
REQ-002 SHALL have parameter NUM_CORES, default 4, number of PE array cores; CORE_W = $clog2(NUM_CORES), minimum 1.
REQ-003 SHALL have parameter BURST_WIDTH, default 6, burst length bit width.
REQ-004 SHALL have ports, in order:
- w_clock  in  1  clock; all state changes on rising edge.
- w_reset_n  in  1  asynchronous active-low reset.
- w_cfg_we  in  1  descriptor table write strobe.
- w_cfg_core  in  CORE_W  core index of the descriptor written.
- w_cfg_stage  in  2  stage of the descriptor: 0 config, 1 weights, 2 acts, 3 psum.
- w_cfg_addr  in  MAIN_MEM_ADDR_WIDTH  descriptor base address.
- w_cfg_burst  in  BURST_WIDTH  descriptor burst length; 0 means skip the stage.
- w_job_valid  in  1  job request from the arbiter.
- w_job_core  in  CORE_W  core served by the job.
- w_job_rw  in  1  1 = read job (core load), 0 = write job (core unload).
- w_job_ready  out  1  sequencer can accept a job.
- w_mem_valid  out  1  memory beat valid.
- w_mem_ready  in  1  memory accepts the beat.
- w_mem_addr  out  MAIN_MEM_ADDR_WIDTH  beat address.
- w_mem_rw  out  1  copy of the job's w_job_rw.
- w_mem_burst  out  BURST_WIDTH  burst length on the first beat of a stage, 0 on all other beats.
- w_done  out  1  one-cycle pulse at job completion.
- w_done_core  out  CORE_W  core index of the completed job, valid while w_done=1.

Function
REQ-005 SHALL hold a descriptor table of NUM_CORES x 4 entries; each entry is {addr, burst}.
REQ-006 A table write SHALL occur on a clock edge with w_cfg_we=1; writes with w_cfg_core >= NUM_CORES SHALL be ignored; writes SHALL be accepted in every state.
REQ-007 SHALL implement states IDLE, LOAD, XFER, NEXT and DONE.
REQ-008 w_job_ready SHALL be 1 only in IDLE; a job SHALL be accepted when w_job_valid=1 and w_job_ready=1.
REQ-009 On accept, SHALL latch core and rw; stage SHALL be set to 0 for a read job and 3 for a write job; next state SHALL be LOAD.
REQ-010 LOAD SHALL copy the table entry {core, stage} into r_addr and r_left.
- A table write to the same entry in that cycle SHALL NOT be seen (read-before-write).
- Out-of-range core SHALL read as {0, 0}.
- Next state SHALL be XFER if burst != 0, else NEXT.
REQ-011 In XFER, w_mem_valid SHALL be 1 with w_mem_addr = r_addr.
- w_mem_burst SHALL equal the latched burst on the first beat of the stage and 0 otherwise.
- All mem outputs SHALL hold stable while w_mem_valid=1 and w_mem_ready=0.
REQ-012 On each XFER handshake, r_addr SHALL increment by 1 (modulo 2^MAIN_MEM_ADDR_WIDTH, wrapping) and r_left SHALL decrement; the handshake with r_left=1 SHALL move the state to NEXT.
REQ-013 NEXT SHALL go to DONE if stage is 2 (read) or 3 (write); otherwise stage SHALL increment and the state SHALL go to LOAD.
REQ-014 DONE SHALL assert w_done=1 with w_done_core for exactly one cycle, then go to IDLE.
REQ-015 Latency: accept at cycle T gives LOAD at T+1 and the first w_mem_valid at T+2; with continuous ready, a stage of burst L SHALL occupy L XFER cycles.
REQ-016 w_mem_valid SHALL be 0 outside XFER; a new job SHALL NOT be accepted while DONE is active.

Reset
REQ-017 w_reset_n=0 SHALL asynchronously force state IDLE, clear every descriptor entry to {0,0}, and clear stage, r_addr and r_left.
REQ-018 During reset, w_mem_valid, w_done, w_mem_addr, w_mem_rw, w_mem_burst and w_done_core SHALL be 0 and w_job_ready SHALL be 0.
REQ-019 After release, w_job_ready SHALL be 1 from the first rising edge.
REQ-020 Reset mid-burst SHALL abort the job with no w_done pulse.

Verification
REQ-021 Core 1 read, entries {0x100,2},{0x200,1},{0x300,3}, ready=1 -> beats 0x100(b2),0x101,0x200(b1),0x300(b3),0x301,0x302 with rw=1; then w_done=1 with w_done_core=1.
REQ-022 Core 2 write, psum {0xFFFFFFFE,3} -> beats 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 with rw=0; done.
REQ-023 Core 0 read with weights burst=0 -> no weights beats; the acts beats follow config NEXT/LOAD directly.
REQ-024 w_mem_ready held 0 for 5 cycles on the second beat -> addr and burst stable throughout; no extra beats.
REQ-025 Table write to the active entry during XFER -> the current job is unchanged and the next job uses the new value.
REQ-026 w_reset_n low during the third beat -> w_mem_valid=0 immediately, no w_done pulse, all entries read as burst 0 afterwards.
